uart_tx_core: RTL and testbench

//  Parametrised single-clock UART transmitter, successor to the fixed TX block.
//  - Internal baud divider, oversampled bit timing.
//  - Runtime frame format: 5-9 data bits; none/odd/even/mark/space parity; 1/1.5/2 stop bits.
//  - valid/ready byte input, normally fed by the TX FIFO; drives the serial line pin.

---
 rtl/uart_pkg.sv | 63 ++++++
 rtl/uart_baud_gen.sv | 30 +++
 rtl/uart_tx_core.sv | 205 ++++++++++++++++++++
 tb/tb_uart_tx_core.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-format codes, their decoders and the TX FSM state encoding.
// Kept apart from the transmitter so the RX successor can reuse the same decoders.
package uart_pkg;

  typedef enum logic [2:0] {
    PAR_NONE  = 3'b000,
    PAR_ODD   = 3'b001,
    PAR_EVEN  = 3'b010,
    PAR_MARK  = 3'b011,
    PAR_SPACE = 3'b100
  } parity_e;

  typedef enum logic [1:0] {
    STOP_ONE      = 2'b00,
    STOP_ONE_HALF = 2'b01,
    STOP_TWO      = 2'b10
  } stop_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  // Codes 0..4 select 5..9 bits; anything else, or wider than the payload port, falls back to 8.
  function automatic logic [3:0] decode_data_bits(input logic [2:0] code,
                                                  input int unsigned data_w);
    logic [3:0] n;
    n = (code <= 3'd4) ? ({1'b0, code} + 4'd5) : 4'd8;
    if (32'(n) > data_w) n = 4'd8;
    return n;
  endfunction

  function automatic parity_e decode_parity(input logic [2:0] code);
    parity_e mode;
    case (code)
      3'b001:  mode = PAR_ODD;
      3'b010:  mode = PAR_EVEN;
      3'b011:  mode = PAR_MARK;
      3'b100:  mode = PAR_SPACE;
      default: mode = PAR_NONE;
    endcase
    return mode;
  endfunction

  function automatic stop_e decode_stop(input logic [1:0] code);
    return (code == 2'b11) ? STOP_ONE : stop_e'(code);
  endfunction

  function automatic logic parity_bit(input parity_e mode, input logic data_xor);
    logic p;
    case (mode)
      PAR_ODD:  p = ~data_xor;
      PAR_EVEN: p = data_xor;
      PAR_MARK: p = 1'b1;
      default:  p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud-rate divider: one tick every div+1 clocks, restartable with clr.
// pre_tick flags the clock just before a tick (always high when div is 0).
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick,
  output logic             pre_tick
);

  logic [DIV_W-1:0] cnt_q;

  assign tick     = (cnt_q == div);
  assign pre_tick = (div == '0) || (cnt_q == div - DIV_W'(1));

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_core.sv
// Single-clock UART transmitter with runtime frame format and valid/ready payload input.
// Define UART_TX_CTS_EN to add a synchronised active-low cts_n input that gates new frames.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int DATA_W     = 9,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic              tx_en,
  input  logic [2:0]        data_bits,
  input  logic [2:0]        parity,
  input  logic [1:0]        stop_bits,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
`ifdef UART_TX_CTS_EN
  input  logic              cts_n,
`endif
  output logic              s_ready,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  localparam int TICK_W = $clog2(OVERSAMPLE * 3 / 2);
  localparam logic [TICK_W-1:0] TICK_LAST      = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] TICK_LAST_HALF = TICK_W'(OVERSAMPLE * 3 / 2 - 1);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [3:0]          nbits_q, nbits_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  parity_e             par_mode_q, par_mode_d;
  logic                par_bit_q, par_bit_d;
  stop_e               stop_q, stop_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                tx_q, tx_d;
  logic                done_q, done_d;
  logic                run_q;

  logic                tick, pre_tick;
  logic                accept;
  logic [3:0]          nbits_in;
  logic [DATA_W-1:0]   data_masked;
  logic [TICK_W-1:0]   stop_tick_last, bit_tick_last;
  logic                bit_end, final_stop_bit, frame_end;

  uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (state_q == ST_IDLE),
    .div      (div_q),
    .tick     (tick),
    .pre_tick (pre_tick)
  );

`ifdef UART_TX_CTS_EN
  logic [1:0] cts_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cts_sync_q <= 2'b11;
    else        cts_sync_q <= {cts_sync_q[0], cts_n};
  end

  assign s_ready = run_q & (state_q == ST_IDLE) & tx_en & ~cts_sync_q[1];
`else
  assign s_ready = run_q & (state_q == ST_IDLE) & tx_en;
`endif

  assign accept      = s_valid & s_ready;
  assign nbits_in    = decode_data_bits(data_bits, DATA_W);
  assign data_masked = s_data & ~({DATA_W{1'b1}} << nbits_in);

  assign tx      = tx_q;
  assign busy    = (state_q != ST_IDLE);
  assign tx_done = done_q;

  // The frame's final clock is spent in IDLE with tx_done high, so a queued byte
  // starts its start bit on the very next clock and every bit still lasts exactly T.
  assign stop_tick_last = (stop_q == STOP_ONE_HALF) ? TICK_LAST_HALF : TICK_LAST;
  assign bit_tick_last  = (state_q == ST_STOP) ? stop_tick_last : TICK_LAST;
  assign bit_end        = tick && (tick_cnt_q == bit_tick_last);
  assign final_stop_bit = (stop_q == STOP_TWO) ? (bit_cnt_q == 4'd1) : 1'b1;
  assign frame_end      = final_stop_bit && pre_tick &&
                          (tick_cnt_q == ((div_q == '0) ? stop_tick_last - TICK_W'(1)
                                                        : stop_tick_last));

  // NOTE: every next-state signal gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    nbits_d    = nbits_q;
    bit_cnt_d  = bit_cnt_q;
    tick_cnt_d = tick_cnt_q;
    par_mode_d = par_mode_q;
    par_bit_d  = par_bit_q;
    stop_d     = stop_q;
    div_d      = div_q;
    tx_d       = tx_q;
    done_d     = 1'b0;

    if (state_q != ST_IDLE && tick) begin
      tick_cnt_d = bit_end ? '0 : tick_cnt_q + TICK_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        tx_d       = 1'b1;
        tick_cnt_d = '0;
        if (accept) begin
          state_d    = ST_START;
          tx_d       = 1'b0;
          shift_d    = s_data;
          nbits_d    = nbits_in;
          par_mode_d = decode_parity(parity);
          par_bit_d  = parity_bit(decode_parity(parity), ^data_masked);
          stop_d     = decode_stop(stop_bits);
          div_d      = baud_div;
          bit_cnt_d  = '0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == nbits_q - 4'd1) begin
            bit_cnt_d = '0;
            if (par_mode_q != PAR_NONE) begin
              state_d = ST_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d   = ST_STOP;
          tx_d      = 1'b1;
          bit_cnt_d = '0;
        end
      end
      ST_STOP: begin
        tx_d = 1'b1;
        if (frame_end) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (bit_end) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      nbits_q    <= 4'd8;
      bit_cnt_q  <= '0;
      tick_cnt_q <= '0;
      par_mode_q <= PAR_NONE;
      par_bit_q  <= 1'b0;
      stop_q     <= STOP_ONE;
      div_q      <= '0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      nbits_q    <= nbits_d;
      bit_cnt_q  <= bit_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      par_mode_q <= par_mode_d;
      par_bit_q  <= par_bit_d;
      stop_q     <= stop_d;
      div_q      <= div_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
      run_q      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core: table of frame formats, random frames against a
// per-clock line model, plus back-to-back, reset, tx_en and (if built with it) CTS sequences.
module tb_uart_tx_core;

  localparam int DATA_W = 9;
  localparam int OS     = 16;
  localparam int DIV_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DIV_W-1:0]  baud_div = '0;
  logic              tx_en = 1'b1;
  logic [2:0]        data_bits = 3'd3;
  logic [2:0]        parity = 3'd0;
  logic [1:0]        stop_bits = 2'd0;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_valid = 1'b0;
  logic              s_ready, tx, busy, tx_done;
`ifdef UART_TX_CTS_EN
  logic              cts_n = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [2:0] nb;
    logic [2:0] par;
    logic [1:0] stop;
    int         div;
    int         data;
    int         exp_len;   // 0: take the length from the model
    int         exp_par;   // -1: no parity bit to check
  } vec_t;

  bit exp_w[$];

  uart_tx_core #(.DATA_W(DATA_W), .OVERSAMPLE(OS), .DIV_W(DIV_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .baud_div  (baud_div),
    .tx_en     (tx_en),
    .data_bits (data_bits),
    .parity    (parity),
    .stop_bits (stop_bits),
    .s_data    (s_data),
    .s_valid   (s_valid),
`ifdef UART_TX_CTS_EN
    .cts_n     (cts_n),
`endif
    .s_ready   (s_ready),
    .tx        (tx),
    .busy      (busy),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expected line level for every clock of one frame, built from the frame rules.
  task automatic build_model(input vec_t v, output int len, output int n);
    int  t, stop_clks, ones;
    bit  has_par, pbit;
    n = (v.nb <= 3'd4) ? int'(v.nb) + 5 : 8;
    if (n > DATA_W) n = 8;
    t = OS * (v.div + 1);
    ones = 0;
    for (int i = 0; i < n; i++) ones += (v.data >> i) & 1;
    has_par = 1'b1;
    pbit    = 1'b0;
    case (v.par)
      3'd1:    pbit = (ones % 2 == 0);
      3'd2:    pbit = (ones % 2 == 1);
      3'd3:    pbit = 1'b1;
      3'd4:    pbit = 1'b0;
      default: has_par = 1'b0;
    endcase
    stop_clks = (v.stop == 2'd1) ? t * 3 / 2 : (v.stop == 2'd2) ? 2 * t : t;
    exp_w.delete();
    for (int c = 0; c < t; c++) exp_w.push_back(1'b0);
    for (int i = 0; i < n; i++)
      for (int c = 0; c < t; c++) exp_w.push_back(((v.data >> i) & 1) != 0);
    if (has_par)
      for (int c = 0; c < t; c++) exp_w.push_back(pbit);
    for (int c = 0; c < stop_clks; c++) exp_w.push_back(1'b1);
    len = exp_w.size();
  endtask

  // Returns just after a falling edge in the clock before the accepting rising edge.
  task automatic wait_ready(output bit got);
    got = 1'b0;
    #1;
    for (int w = 0; w < 64; w++) begin
      if (s_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    int   len, n, t, mism, done_idx, done_cnt, busy_cnt, exp_len;
    bit   got;
    logic cap[$];
    build_model(v, len, n);
    t = OS * (v.div + 1);
    exp_len = (v.exp_len != 0) ? v.exp_len : len;
    @(negedge clk);
    data_bits = v.nb;
    parity    = v.par;
    stop_bits = v.stop;
    baud_div  = DIV_W'(v.div);
    s_data    = DATA_W'(v.data);
    s_valid   = 1'b1;
    wait_ready(got);
    if (!got) begin
      check({tag, " ready"}, 32'd0, 32'd1);
      s_valid = 1'b0;
      return;
    end
    @(posedge clk);
    mism = 0; done_idx = -1; done_cnt = 0; busy_cnt = 0;
    for (int k = 0; k < len + 2; k++) begin
      @(negedge clk);
      cap.push_back(tx);
      if (tx !== ((k < len) ? exp_w[k] : 1'b1)) mism++;
      if (tx_done === 1'b1) begin
        done_cnt++;
        if (done_idx < 0) done_idx = k;
      end
      if (busy === 1'b1) busy_cnt++;
      if (k == 0) begin
        // Inputs changed mid-frame must not disturb the frame in flight.
        s_valid   = 1'b0;
        baud_div  = DIV_W'($urandom_range(0, 15));
        data_bits = 3'($urandom);
        parity    = 3'($urandom);
        stop_bits = 2'($urandom);
        s_data    = DATA_W'($urandom);
      end
    end
    check({tag, " wave"}, mism, 0);
    check({tag, " done_at"}, done_idx, exp_len - 1);
    check({tag, " done_cnt"}, done_cnt, 1);
    check({tag, " busy_clks"}, busy_cnt, len - 1);
    if (v.exp_par >= 0) check({tag, " parity"}, cap[(1 + n) * t + t / 2], v.exp_par);
  endtask

  initial begin
    vec_t tbl[10];
    vec_t v, v2;
    bit   got;
    bit   q[$];
    int   len, n, mism, d0, d1, dcnt, rcnt;

    tbl = '{
      '{3'd3, 3'd0, 2'd0, 3, 'hA5,  640, -1},   // 8N1, baud_div 3
      '{3'd2, 3'd2, 2'd0, 0, 'h35,  160,  0},   // 7E1
      '{3'd2, 3'd1, 2'd0, 0, 'h35,  160,  1},   // 7O1
      '{3'd2, 3'd3, 2'd0, 0, 'h35,  160,  1},   // 7 mark
      '{3'd2, 3'd4, 2'd0, 0, 'h35,  160,  0},   // 7 space
      '{3'd2, 3'd2, 2'd0, 0, 'hB5,  160,  0},   // bit 7 outside the frame
      '{3'd4, 3'd0, 2'd2, 0, 'h1FF, 192, -1},   // 9N2
      '{3'd0, 3'd0, 2'd1, 0, 'h1F,  120, -1},   // 5N1.5
      '{3'd1, 3'd1, 2'd2, 1, 'h2A,  320,  0},   // 6O2, baud_div 1
      '{3'd7, 3'd7, 2'd3, 0, 'h1C3, 160, -1}    // illegal codes -> 8N1
    };

    // Reset state
    repeat (3) @(negedge clk);
    check("rst tx", tx, 1);
    check("rst busy", busy, 0);
    check("rst tx_done", tx_done, 0);
    check("rst s_ready", s_ready, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("idle s_ready", s_ready, 1);

    foreach (tbl[i]) run_frame(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 8; i++) begin
      v.nb      = 3'($urandom_range(0, 7));
      v.par     = 3'($urandom_range(0, 7));
      v.stop    = 2'($urandom_range(0, 3));
      v.div     = $urandom_range(0, 2);
      v.data    = $urandom_range(0, 511);
      v.exp_len = 0;
      v.exp_par = -1;
      run_frame(v, $sformatf("rnd%0d", i));
    end

    // Back-to-back 0x55 then 0xAA, s_valid held: no idle clock between frames
    v  = '{3'd3, 3'd0, 2'd0, 0, 'h55, 0, -1};
    v2 = '{3'd3, 3'd0, 2'd0, 0, 'hAA, 0, -1};
    build_model(v, len, n);
    q = exp_w;
    build_model(v2, len, n);
    q = {q, exp_w};
    @(negedge clk);
    data_bits = 3'd3; parity = 3'd0; stop_bits = 2'd0; baud_div = '0;
    s_data = DATA_W'(9'h055); s_valid = 1'b1;
    wait_ready(got);
    check("b2b ready", got, 1);
    @(posedge clk);
    mism = 0; d0 = -1; d1 = -1; dcnt = 0;
    for (int k = 0; k < 322; k++) begin
      @(negedge clk);
      if (tx !== ((k < q.size()) ? q[k] : 1'b1)) mism++;
      if (tx_done === 1'b1) begin
        dcnt++;
        if (d0 < 0) d0 = k;
        else if (d1 < 0) d1 = k;
      end
      if (k == 0)   s_data = DATA_W'(9'h0AA);
      if (k == 160) s_valid = 1'b0;
    end
    check("b2b wave", mism, 0);
    check("b2b done1_at", d0, 159);
    check("b2b done2_at", d1, 319);
    check("b2b done_cnt", dcnt, 2);

    // tx_en dropped mid-frame: frame completes, nothing further accepted
    v = '{3'd3, 3'd0, 2'd0, 0, 'h3C, 0, -1};
    build_model(v, len, n);
    @(negedge clk);
    s_data = DATA_W'(9'h03C); s_valid = 1'b1; tx_en = 1'b1;
    wait_ready(got);
    check("txen ready", got, 1);
    @(posedge clk);
    mism = 0; d0 = -1; rcnt = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (tx !== ((k < len) ? exp_w[k] : 1'b1)) mism++;
      if (tx_done === 1'b1 && d0 < 0) d0 = k;
      if (k > 50 && s_ready !== 1'b0) rcnt++;
      if (k == 0)  s_data = DATA_W'(9'h1E1);
      if (k == 50) tx_en = 1'b0;
    end
    check("txen wave", mism, 0);
    check("txen done_at", d0, 159);
    check("txen ready_seen", rcnt, 0);
    check("txen busy_after", busy, 0);
    s_valid = 1'b0;
    tx_en   = 1'b1;

    // Reset during data bit 3 of an all-zero byte
    @(negedge clk);
    s_data = '0; s_valid = 1'b1;
    wait_ready(got);
    check("rstmid ready", got, 1);
    @(posedge clk);
    for (int k = 0; k <= 72; k++) begin
      @(negedge clk);
      if (k == 0) s_valid = 1'b0;
    end
    check("rstmid tx_before", tx, 0);
    rst_n = 1'b0;
    #1;
    check("rstmid tx", tx, 1);
    check("rstmid busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("rstmid idle_ready", s_ready, 1);

`ifdef UART_TX_CTS_EN
    // cts_n high blocks acceptance; deasserting it mid-frame never truncates a frame
    cts_n = 1'b1;
    repeat (4) @(negedge clk);
    s_valid = 1'b1;
    rcnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (s_ready !== 1'b0) rcnt++;
    end
    check("cts ready_blocked", rcnt, 0);
    check("cts busy_blocked", busy, 0);
    v = '{3'd3, 3'd0, 2'd0, 0, 'h96, 0, -1};
    build_model(v, len, n);
    s_data = DATA_W'(9'h096);
    cts_n = 1'b0;
    wait_ready(got);
    check("cts ready", got, 1);
    @(posedge clk);
    mism = 0; d0 = -1; rcnt = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (tx !== ((k < len) ? exp_w[k] : 1'b1)) mism++;
      if (tx_done === 1'b1 && d0 < 0) d0 = k;
      if (k > 20 && s_ready !== 1'b0) rcnt++;
      if (k == 20) cts_n = 1'b1;
    end
    check("cts wave", mism, 0);
    check("cts done_at", d0, 159);
    check("cts next_held", rcnt, 0);
    s_valid = 1'b0;
    cts_n   = 1'b0;
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
